eth_pkt_gen: RTL



---
 rtl/eth_pkt_gen.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/eth_pkt_gen.sv
// Ethernet packet source: emits runs of fixed-length packets with a
// deterministic (n + p) mod 256 byte pattern, honours ready backpressure
// and keeps wrap-around packet and byte counters.
//
// state | meaning
// IDLE  | waiting for start; parameters free to change
// SEND  | presenting packet words; advances only on val && ready
// GAP   | inter-packet idle, down-counts ifg cycles
module eth_pkt_gen #(
  parameter int D_WIDTH   = 64,
  parameter int MOD_WIDTH = 3,
  parameter int LEN_W     = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [LEN_W-1:0]     pkt_len_i,
  input  logic [31:0]          pkt_num_i,
  input  logic [7:0]           ifg_i,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 sop_o,
  output logic                 eop_o,
  output logic [MOD_WIDTH-1:0] mod_o,
  output logic                 val_o,
  input  logic                 ready_i,
  output logic                 tuser_o,
  output logic                 busy_o,
  output logic [31:0]          sent_pkt_o,
  output logic [47:0]          sent_bytes_o
);

  localparam int               BYTES   = D_WIDTH / 8;
  localparam logic [LEN_W-1:0] BYTES_L = LEN_W'(BYTES);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(60);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t               state_q;
  logic [LEN_W-1:0]     len_q;
  logic [31:0]          num_q;
  logic [7:0]           ifg_q;
  logic [7:0]           gap_cnt_q;
  logic [31:0]          p_q;
  logic [LEN_W-1:0]     widx_q;
  logic                 stop_pend_q;
  logic [D_WIDTH-1:0]   data_q;
  logic                 sop_q;
  logic                 eop_q;
  logic [MOD_WIDTH-1:0] mod_q;
  logic                 val_q;
  logic                 busy_q;
  logic [31:0]          sent_pkt_q;
  logic [47:0]          sent_bytes_q;

  logic                 xfer;
  logic                 end_run;
  logic [31:0]          p_inc;
  logic [LEN_W-1:0]     len_start;
  logic                 ld_go;
  logic [LEN_W-1:0]     idx_d;
  logic [7:0]           pkt_d;
  logic [LEN_W-1:0]     last_idx;
  logic [D_WIDTH-1:0]   data_d;
  logic                 eop_d;
  logic [MOD_WIDTH-1:0] mod_d;

  // Word idx of a packet: byte n = idx*BYTES + b carries (n + pkt) mod 256,
  // bytes past the packet length are zero.
  function automatic logic [D_WIDTH-1:0] beat_word(input logic [LEN_W-1:0] idx,
                                                   input logic [7:0]       pkt,
                                                   input logic [LEN_W-1:0] len);
    logic [D_WIDTH-1:0] w;
    logic [31:0]        n;
    w = '0;
    for (int b = 0; b < BYTES; b++) begin
      n = 32'(idx) * BYTES + 32'(b);
      if (n < 32'(len)) w[D_WIDTH-1-8*b -: 8] = n[7:0] + pkt;
    end
    return w;
  endfunction

  assign xfer      = val_q && ready_i;
  assign p_inc     = p_q + 32'd1;
  assign end_run   = ((num_q != 32'd0) && (p_inc == num_q)) || stop_pend_q || stop_i;
  assign len_start = (pkt_len_i < MIN_LEN) ? MIN_LEN : pkt_len_i;

  // Next word to present and whether it is loaded this cycle.
  always_comb begin
    idx_d = widx_q + LEN_W'(1);
    pkt_d = p_q[7:0];
    ld_go = 1'b0;
    case (state_q)
      SEND: begin
        if (!val_q) begin
          // first word of a run, one cycle after start was accepted
          idx_d = '0;
          ld_go = 1'b1;
        end else if (xfer) begin
          if (!eop_q) begin
            ld_go = 1'b1;
          end else if (!end_run && (ifg_q == 8'd0)) begin
            idx_d = '0;
            pkt_d = p_inc[7:0];
            ld_go = 1'b1;
          end
        end
      end
      GAP: begin
        idx_d = '0;
        ld_go = (gap_cnt_q == 8'd1) && !stop_pend_q && !stop_i;
      end
      default: ;
    endcase
    last_idx = (len_q - LEN_W'(1)) / BYTES_L;
    data_d   = beat_word(idx_d, pkt_d, len_q);
    eop_d    = (idx_d == last_idx);
    mod_d    = eop_d ? MOD_WIDTH'(len_q % BYTES_L) : '0;
  end

  // Sequencer, counters and registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= '0;
      num_q        <= '0;
      ifg_q        <= '0;
      gap_cnt_q    <= '0;
      p_q          <= '0;
      widx_q       <= '0;
      stop_pend_q  <= 1'b0;
      data_q       <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      mod_q        <= '0;
      val_q        <= 1'b0;
      busy_q       <= 1'b0;
      sent_pkt_q   <= '0;
      sent_bytes_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          stop_pend_q <= 1'b0;
          if (start_i && !stop_i) begin
            len_q   <= len_start;
            num_q   <= pkt_num_i;
            ifg_q   <= ifg_i;
            p_q     <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (stop_i) stop_pend_q <= 1'b1;
          if (xfer && eop_q) begin
            sent_pkt_q   <= sent_pkt_q + 32'd1;
            sent_bytes_q <= sent_bytes_q + 48'(len_q) + 48'd4;
            p_q          <= p_inc;
            if (end_run) begin
              state_q     <= IDLE;
              stop_pend_q <= 1'b0;
              val_q       <= 1'b0;
              busy_q      <= 1'b0;
              sop_q       <= 1'b0;
              eop_q       <= 1'b0;
            end else if (ifg_q != 8'd0) begin
              state_q   <= GAP;
              gap_cnt_q <= ifg_q;
              val_q     <= 1'b0;
              sop_q     <= 1'b0;
              eop_q     <= 1'b0;
            end
          end
        end
        GAP: begin
          if (stop_i || stop_pend_q) begin
            state_q     <= IDLE;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (gap_cnt_q == 8'd1) begin
            state_q <= SEND;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (ld_go) begin
        widx_q <= idx_d;
        data_q <= data_d;
        sop_q  <= (idx_d == '0);
        eop_q  <= eop_d;
        mod_q  <= mod_d;
        val_q  <= 1'b1;
        busy_q <= 1'b1;
      end
    end
  end

  assign data_o       = data_q;
  assign sop_o        = sop_q;
  assign eop_o        = eop_q;
  assign mod_o        = mod_q;
  assign val_o        = val_q;
  assign busy_o       = busy_q;
  assign tuser_o      = 1'b0;
  assign sent_pkt_o   = sent_pkt_q;
  assign sent_bytes_o = sent_bytes_q;

endmodule
